freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter GATE_CYCLES, default CLK_FREQ, gate window length in clkin cycles (1 s at default); legal range 2..2^32-1.
REQ-003 SHALL have parameter CNT_W, default 32, width of the edge counter and result.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clkin  input  1  system clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port en  input  1  measurement enable, synchronous to clkin.
REQ-007 SHALL have port sigin  input  1  measured signal, asynchronous to clkin.
REQ-008 SHALL have port freq  output  CNT_W  rising-edge count of the last completed gate window (Hz at default gate).
REQ-009 SHALL have port valid  output  1  one-cycle pulse when freq updates.
REQ-010 SHALL have port ovf  output  1  sticky until next update; edge count saturated in the window just reported.
REQ-011 SHALL have port busy  output  1  high while a gate window is open.

Function
REQ-012 sigin SHALL pass through a 2-flop synchronizer, then a rising-edge detector producing a 1-cycle pulse; a sigin rise meeting setup before clkin edge N yields the edge pulse in cycle N+2.
REQ-013 FSM states SHALL be IDLE, MEASURE, LATCH.
REQ-014 IDLE: gate counter = 0, edge counter = 0, busy = 0; en = 1 moves to MEASURE on the next cycle.
REQ-015 MEASURE: busy = 1; gate counter increments each cycle; edge counter increments on each edge pulse.
REQ-016 The window SHALL be exactly GATE_CYCLES cycles: edge pulses in MEASURE cycles 0..GATE_CYCLES-1 count; gate counter reaching GATE_CYCLES-1 moves to LATCH.
REQ-017 An edge pulse in the final MEASURE cycle SHALL be included in the result.
REQ-018 LATCH (one cycle): freq <= edge count; ovf <= saturation flag; valid = 1; counters cleared.
REQ-019 From LATCH, the FSM SHALL return to MEASURE if en = 1 and to IDLE otherwise.
REQ-020 An edge pulse during LATCH SHALL be dropped, giving a fixed one-cycle dead time between windows.
REQ-021 The edge counter SHALL saturate at 2^CNT_W-1 without wrapping, and set an internal saturation flag cleared at window start.
REQ-022 The gate counter SHALL be 32 bits wide and SHALL NOT wrap within a window.
REQ-023 When en is deasserted in MEASURE, the FSM SHALL go to IDLE next cycle, discard the partial count, assert no valid, and hold freq and ovf.
REQ-024 When en is reasserted, a full new window SHALL start; no partial result is ever reported.
REQ-025 valid SHALL be high only in LATCH, never two cycles consecutively.
REQ-026 freq and ovf SHALL change only in LATCH.

Reset
REQ-027 When rst is asserted, all flops SHALL clear immediately and asynchronously: FSM IDLE, synchronizer flops 0, counters 0, freq 0, valid 0, ovf 0, busy 0.
REQ-028 Reset mid-window SHALL discard the window; after release the block SHALL behave as from power-up.
REQ-029 Reset release SHALL be synchronous to clkin for the FSM; the first MEASURE cycle SHALL be no earlier than the 2nd clkin edge after release with en = 1.

Structure
REQ-030 A shared package/header freq_pkg SHALL hold the FSM state encodings (IDLE = 2'd0, MEASURE = 2'd1, LATCH = 2'd2) and the CLK_FREQ default constant.
REQ-031 A sub-module sync_edge SHALL contain the 2-flop synchronizer and rising-edge detector (ports clkin, rst, din, pulse), reusable for other asynchronous inputs.
REQ-032 The gate counter, edge counter, FSM and result registers SHALL reside in freq_meter; no derived clocks; all flops on clkin.

Verification (sim with GATE_CYCLES = 1000)
REQ-033 Apply sigin as a square wave of period 10 clkin cycles with en = 1 continuously -> each valid reports freq = 100 (±1 for phase), ovf = 0, with valid pulses exactly 1001 cycles apart.
REQ-034 Hold sigin constant 1 -> freq = 0, ovf = 0 every window; toggle sigin every cycle (period 2) -> freq = 500 ±1.
REQ-035 Deassert en 400 cycles into a window -> no valid, freq keeps its previous value, busy falls next cycle; reassert en -> the first valid comes 1000 cycles after MEASURE entry.
REQ-036 With CNT_W = 4 and sigin period 10 -> freq = 15, ovf = 1; then slow sigin to period 200 -> next freq = 5, ovf = 0.
REQ-037 Assert rst asynchronously between clkin edges mid-window -> all outputs 0 immediately; after release with en = 1, the first valid is a full-window result.
REQ-038 Place a single sigin rise so its edge pulse lands in the final MEASURE cycle -> counted; move it to the LATCH cycle -> not counted in either window.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared definitions for the frequency meter: FSM state encodings and the
// default system clock rate.
package freq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LATCH   = 2'd2
    } state_e;

    localparam int unsigned CLK_FREQ_DEFAULT = 100_000_000;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; usable for any
// asynchronous single-bit input.
module sync_edge (
    input  logic clkin,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // Both terms come straight from flops, so the pulse is glitch-free.
    assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of an asynchronous input over a
// fixed window of clkin cycles and reports the count once per window.
module freq_meter
    import freq_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = CLK_FREQ_DEFAULT,
    parameter int unsigned GATE_CYCLES = CLK_FREQ,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             en,
    input  logic             sigin,
    output logic [CNT_W-1:0] freq,
    output logic             valid,
    output logic             ovf,
    output logic             busy
);

    localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);

    state_e             state_q, state_d;
    logic               arm_q, arm_d;
    logic [31:0]        gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   freq_q, freq_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   edge_inc;
    logic               sat_inc;
    logic               edge_pulse;
    logic               last_cycle;

    sync_edge u_sync (
        .clkin (clkin),
        .rst   (rst),
        .din   (sigin),
        .pulse (edge_pulse)
    );

    assign last_cycle = (gate_cnt_q == GATE_LAST);

    // Saturating edge increment; sat_inc records that at least one edge was lost.
    always_comb begin
        edge_inc = edge_cnt_q;
        sat_inc  = sat_q;
        if (edge_pulse) begin
            if (&edge_cnt_q) begin
                sat_inc = 1'b1;
            end else begin
                edge_inc = edge_cnt_q + CNT_W'(1);
            end
        end
    end

    // arm_q keeps the FSM in IDLE for the first edge after reset release.
    always_comb begin
        arm_d   = 1'b1;
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en && arm_q) state_d = MEASURE;
            MEASURE: begin
                if (!en)             state_d = IDLE;
                else if (last_cycle) state_d = LATCH;
            end
            LATCH:   state_d = en ? MEASURE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
        end
    end

    always_comb begin
        busy  = (state_q == MEASURE);
        valid = (state_q == LATCH);
    end

    // The result is loaded on the edge entering LATCH so it is visible
    // together with valid; the final MEASURE cycle's edge is included.
    always_comb begin
        gate_cnt_d = 32'd0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        if (state_q == MEASURE && en) begin
            if (last_cycle) begin
                freq_d = edge_inc;
                ovf_d  = sat_inc;
            end else begin
                gate_cnt_d = gate_cnt_q + 32'd1;
                edge_cnt_d = edge_inc;
                sat_d      = sat_inc;
            end
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            gate_cnt_q <= 32'd0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
        end
    end

    assign freq = freq_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (32-bit and 4-bit counters) share one
// stimulus; a window-counting model checks every reported result.
module tb_freq_meter;

    localparam int G = 1000;
    localparam int NEDGE = 60000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic sigin = 1'b0;

    logic [31:0] freq_a;
    logic        valid_a, ovf_a, busy_a;
    logic [3:0]  freq_b;
    logic        valid_b, ovf_b, busy_b;

    freq_meter #(.GATE_CYCLES(G)) dut_a (
        .clkin (clk), .rst (rst), .en (en), .sigin (sigin),
        .freq (freq_a), .valid (valid_a), .ovf (ovf_a), .busy (busy_a)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut_b (
        .clkin (clk), .rst (rst), .en (en), .sigin (sigin),
        .freq (freq_b), .valid (valid_b), .ovf (ovf_b), .busy (busy_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Ideal input model: a rise sampled at edge N is counted by the edge N+2.
    int edge_n = 0;
    bit pulse_at [0:NEDGE-1];
    bit prev_s = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst && sigin && !prev_s && edge_n + 3 < NEDGE) pulse_at[edge_n + 3] = 1'b1;
            prev_s = rst ? 1'b0 : sigin;
            edge_n = edge_n + 1;
        end
    end

    // A result reported after edge v covers the rises counted at edges v-G+1..v.
    function automatic int window_count(input int v);
        int c = 0;
        for (int e = v - G + 1; e <= v; e++) if (e >= 0 && pulse_at[e]) c++;
        return c;
    endfunction

    // Square-wave generator; half == 0 leaves sigin to the directed code.
    int half = 0;
    int ph = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (half > 0) begin
                ph++;
                if (ph >= half) begin
                    ph = 0;
                    sigin = ~sigin;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        int busy_run = 0;
        logic [31:0] pf_a = '0;
        logic [3:0]  pf_b = '0;
        logic        po_a = 1'b0, po_b = 1'b0, pv = 1'b0;
        int cnt;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_run = 0;
                pf_a = '0; pf_b = '0; po_a = 1'b0; po_b = 1'b0; pv = 1'b0;
            end else begin
                chk("valid_b_tracks_a", valid_b, valid_a);
                if (valid_a) begin
                    cnt = window_count(edge_n);
                    chk("model_freq_a", freq_a, cnt);
                    chk("model_ovf_a", ovf_a, 0);
                    chk("model_freq_b", freq_b, (cnt > 15) ? 15 : cnt);
                    chk("model_ovf_b", ovf_b, (cnt > 15) ? 1 : 0);
                    chk("window_length", busy_run, G);
                    if (pv) chk("valid_back_to_back", 1, 0);
                end else begin
                    chk("hold_freq_a", freq_a, pf_a);
                    chk("hold_ovf_b", ovf_b, po_b);
                    chk("hold_freq_b", freq_b, pf_b);
                    chk("hold_ovf_a", ovf_a, po_a);
                end
                busy_run = busy_a ? busy_run + 1 : 0;
                pf_a = freq_a; pf_b = freq_b; po_a = ovf_a; po_b = ovf_b; pv = valid_a;
            end
        end
    end

    task automatic wait_valid(output int v);
        v = -1;
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            if (valid_a) begin
                v = edge_n;
                break;
            end
        end
        if (v < 0) chk("valid_timeout", 0, 1);
    endtask

    task automatic wait_edge(input int target);
        while (edge_n < target) @(negedge clk);
    endtask

    initial begin
        int v1, v2, v3, e0, em, f_keep, nvalid;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_freq_a", freq_a, 0);
        chk("rst_valid_a", valid_a, 0);
        chk("rst_ovf_a", ovf_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_freq_b", freq_b, 0);
        chk("rst_ovf_b", ovf_b, 0);
        rst = 1'b0;
        en = 1'b1;
        half = 5;

        // Period 10 with continuous enable
        wait_valid(v1);
        chk_rng("p10_freq_a_1", freq_a, 99, 101);
        chk("p10_freq_b_1", freq_b, 15);
        chk("p10_ovf_b_1", ovf_b, 1);
        wait_valid(v2);
        chk("p10_spacing_1", v2 - v1, 1001);
        chk_rng("p10_freq_a_2", freq_a, 99, 101);
        chk("p10_ovf_a_2", ovf_a, 0);
        wait_valid(v3);
        chk("p10_spacing_2", v3 - v2, 1001);
        chk("p10_freq_a_3", freq_a, 100);

        // Period 200: saturating instance recovers
        half = 100;
        wait_valid(v1);
        wait_valid(v1);
        chk("p200_freq_b", freq_b, 5);
        chk("p200_ovf_b", ovf_b, 0);
        chk("p200_freq_a", freq_a, 5);

        // Period 2
        half = 1;
        wait_valid(v1);
        wait_valid(v1);
        chk_rng("p2_freq_a", freq_a, 499, 501);
        chk("p2_ovf_b", ovf_b, 1);

        // Constant high
        half = 0;
        sigin = 1'b1;
        wait_valid(v1);
        wait_valid(v1);
        chk("const_freq_a", freq_a, 0);
        chk("const_ovf_a", ovf_a, 0);
        chk("const_ovf_b", ovf_b, 0);

        // Enable dropped 400 cycles into a window
        half = 5;
        wait_valid(v1);
        wait_valid(v1);
        f_keep = int'(freq_a);
        wait_edge(v1 + 400);
        en = 1'b0;
        @(negedge clk);
        chk("abort_busy_falls", busy_a, 0);
        nvalid = 0;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if (valid_a) nvalid++;
        end
        chk("abort_no_valid", nvalid, 0);
        chk("abort_freq_held", freq_a, f_keep);
        en = 1'b1;
        e0 = edge_n;
        em = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy_a) begin
                em = edge_n;
                break;
            end
        end
        chk("reen_measure_entry", em - e0, 1);
        wait_valid(v2);
        chk("reen_first_valid", v2 - em, 1000);
        chk("reen_freq_a", freq_a, 100);

        // Asynchronous reset mid-window
        repeat (300) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_freq_a", freq_a, 0);
        chk("arst_busy_a", busy_a, 0);
        chk("arst_valid_a", valid_a, 0);
        chk("arst_freq_b", freq_b, 0);
        chk("arst_ovf_b", ovf_b, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        wait_valid(v1);
        chk("arst_full_window", freq_a, 100);

        // Single rise landing in the final MEASURE cycle, then in LATCH
        half = 0;
        sigin = 1'b0;
        wait_valid(v1);
        wait_valid(v1);
        wait_edge(v1 + 998);
        sigin = 1'b1;
        wait_valid(v2);
        chk("last_cycle_spacing", v2 - v1, 1001);
        chk("last_cycle_counted", freq_a, 1);
        repeat (10) @(negedge clk);
        sigin = 1'b0;
        wait_valid(v3);
        chk("after_last_zero", freq_a, 0);
        wait_edge(v3 + 999);
        sigin = 1'b1;
        wait_valid(v1);
        chk("latch_drop_win1", freq_a, 0);
        wait_valid(v2);
        chk("latch_drop_win2", freq_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
